// File: rtl/alu_exception_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exception_if
// Purpose  : Bundle between the EX stage and the ALU exception controller.
//            The master (pipeline) drives the EX-stage status. The slave
//            (exception controller) returns the flush/redirect request and
//            the captured exception state.
// Ports    : ex_valid, alu_type, opcode, fun, alu_err, ex_pc, eret, stall
//            go from master to slave. flush, redirect, redirect_pc, epc,
//            cause, in_handler, exc_count, fatal go from slave to master.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exception_if #(
   parameter int CNT_W = 16
) ();
   logic             ex_valid;
   logic [1:0]       alu_type;
   logic [5:0]       opcode;
   logic [5:0]       fun;
   logic             alu_err;
   logic [31:0]      ex_pc;
   logic             eret;
   logic             stall;
   logic             flush;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [31:0]      epc;
   logic [4:0]       cause;
   logic             in_handler;
   logic [CNT_W-1:0] exc_count;
   logic             fatal;

   modport master (
      output ex_valid, alu_type, opcode, fun, alu_err, ex_pc, eret, stall,
      input  flush, redirect, redirect_pc, epc, cause, in_handler, exc_count, fatal
   );

   modport slave (
      input  ex_valid, alu_type, opcode, fun, alu_err, ex_pc, eret, stall,
      output flush, redirect, redirect_pc, epc, cause, in_handler, exc_count, fatal
   );
endinterface
`default_nettype wire

// File: rtl/alu_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exception_ctrl
// Purpose  : EX-stage ALU exception controller for the single-issue MIPS
//            core. It captures the faulting PC and the cause (overflow or
//            reserved instruction), flushes the pipeline, and redirects fetch
//            to the handler. On eret it returns fetch to the captured PC.
// Ports    : clk, rst    - core clock and asynchronous active-high reset
//            bus (slave) - EX status in; flush/redirect/epc/cause/count out
// Options  : EXC_TIMEOUT_EN - handler watchdog. The FSM enters HALT and
//            raises a sticky fatal flag after TIMEOUT_CYCLES handler cycles
//            without eret.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exception_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter int          CNT_W        = 16
`ifdef EXC_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic           clk,
   input  logic           rst,
   alu_exception_if.slave bus
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_FLUSH   = 3'd1;
   localparam logic [2:0] c_HANDLER = 3'd2;
   localparam logic [2:0] c_RETURN  = 3'd3;
`ifdef EXC_TIMEOUT_EN
   localparam logic [2:0] c_HALT    = 3'd4;
`endif

   localparam logic [4:0]       c_CAUSE_OV = 5'd12;
   localparam logic [4:0]       c_CAUSE_RI = 5'd10;
   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef EXC_TIMEOUT_EN
   localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_WD_W-1:0] c_WD_ONE  = {{(c_WD_W-1){1'b0}}, 1'b1};
   logic [c_WD_W-1:0] r_wd;
   logic              r_fatal;
`endif

   logic [2:0]       r_state;
   logic             r_flush;
   logic             r_redirect;
   logic [31:0]      r_redirect_pc;
   logic [31:0]      r_epc;
   logic [4:0]       r_cause;
   logic             r_in_handler;
   logic [CNT_W-1:0] r_count;

   logic             w_capture;
   logic [4:0]       w_class;

   // A stalled EX instruction is not captured. It stays in EX and is
   // re-evaluated on the first unstalled cycle.
   assign w_capture = (r_state == c_IDLE) & bus.ex_valid & bus.alu_err & ~bus.stall;

   // Only add/sub (R-type) and addi (I-type) can overflow. Every other
   // erroring ALU op is treated as a reserved instruction.
   always_comb begin
      w_class = c_CAUSE_RI;
      if (bus.alu_type == 2'b01 && (bus.fun == 6'b100000 || bus.fun == 6'b100010))
         w_class = c_CAUSE_OV;
      else if (bus.alu_type == 2'b00 && bus.opcode == 6'b001000)
         w_class = c_CAUSE_OV;
   end

   // Outputs are computed for the next state, so each registered output
   // lines up with the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_IDLE;
         r_flush       <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
         r_epc         <= 32'd0;
         r_cause       <= 5'd0;
         r_in_handler  <= 1'b0;
         r_count       <= '0;
`ifdef EXC_TIMEOUT_EN
         r_wd          <= '0;
         r_fatal       <= 1'b0;
`endif
      end else begin
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
         case (r_state)
            c_IDLE: begin
               // A capture takes priority over an eret in the same cycle.
               // An eret alone in IDLE is ignored.
               if (w_capture) begin
                  r_state       <= c_FLUSH;
                  r_flush       <= 1'b1;
                  r_redirect    <= 1'b1;
                  r_redirect_pc <= HANDLER_ADDR;
                  r_epc         <= bus.ex_pc;
                  r_cause       <= w_class;
                  if (r_count != '1)
                     r_count <= r_count + c_CNT_ONE;
               end
            end
            c_FLUSH: begin
               r_state      <= c_HANDLER;
               r_in_handler <= 1'b1;
`ifdef EXC_TIMEOUT_EN
               r_wd         <= '0;
`endif
            end
            c_HANDLER: begin
               // Nested errors are masked. An eret wins over a concurrent
               // error and also over the watchdog limit.
               if (bus.eret) begin
                  r_state       <= c_RETURN;
                  r_flush       <= 1'b1;
                  r_redirect    <= 1'b1;
                  r_redirect_pc <= r_epc;
                  r_in_handler  <= 1'b0;
               end
`ifdef EXC_TIMEOUT_EN
               else if (r_wd == c_WD_LAST) begin
                  r_state      <= c_HALT;
                  r_fatal      <= 1'b1;
                  r_flush      <= 1'b1;
                  r_in_handler <= 1'b0;
               end else begin
                  r_wd <= r_wd + c_WD_ONE;
               end
`endif
            end
            c_RETURN: begin
               r_state <= c_IDLE;
            end
`ifdef EXC_TIMEOUT_EN
            c_HALT: begin
               // Terminal state. The pipeline is kept flushed until reset.
               r_flush <= 1'b1;
            end
`endif
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.flush       = r_flush;
   assign bus.redirect    = r_redirect;
   assign bus.redirect_pc = r_redirect_pc;
   assign bus.epc         = r_epc;
   assign bus.cause       = r_cause;
   assign bus.in_handler  = r_in_handler;
   assign bus.exc_count   = r_count;
`ifdef EXC_TIMEOUT_EN
   assign bus.fatal       = r_fatal;
`else
   assign bus.fatal       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exception_ctrl
// Purpose  : Self-checking bench for alu_exception_ctrl. Each stimulus that
//            should produce a redirect pushes its expected response. A
//            monitor pops one entry per redirect cycle and compares it.
//            Level checks of the captured state follow the stimulus inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exception_ctrl;

   localparam int c_CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_exception_if #(.CNT_W(c_CW)) bus ();

   alu_exception_ctrl #(
      .HANDLER_ADDR(32'h0000_4180),
      .CNT_W(c_CW)
`ifdef EXC_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic [4:0]  cause;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   exp_cnt  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] epc, input logic [4:0] cause);
      exp_t e;
      e.pc    = pc;
      e.epc   = epc;
      e.cause = cause;
      e.cnt   = exp_cnt[3:0];
      sb.push_back(e);
   endtask

   // Saturating model of the exception counter.
   task automatic bump();
      if (exp_cnt != (1 << c_CW) - 1)
         exp_cnt++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.ex_valid = 1'b0;
      bus.alu_type = 2'b00;
      bus.opcode   = 6'd0;
      bus.fun      = 6'd0;
      bus.alu_err  = 1'b0;
      bus.ex_pc    = 32'd0;
      bus.eret     = 1'b0;
      bus.stall    = 1'b0;
   endtask

   task automatic raise(input logic [31:0] pc, input logic [1:0] t, input logic [5:0] f,
                        input logic [5:0] op, input logic er);
      bus.ex_valid = 1'b1;
      bus.alu_type = t;
      bus.fun      = f;
      bus.opcode   = op;
      bus.ex_pc    = pc;
      bus.alu_err  = 1'b1;
      bus.eret     = er;
   endtask

   task automatic do_ret(input logic [31:0] pc, input logic [4:0] cause);
      bus.eret = 1'b1;
      push(pc, pc, cause);
      cyc();
      bus.eret = 1'b0;
      cyc();
   endtask

   // Monitor: every redirect cycle must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && bus.redirect === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_redirect: got redirect to 0x%0h expected none at %0t",
                     bus.redirect_pc, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("redirect_pc", bus.redirect_pc, e.pc);
            check("redirect_flush", {31'd0, bus.flush}, 32'd1);
            check("redirect_epc", bus.epc, e.epc);
            check("redirect_cause", {27'd0, bus.cause}, {27'd0, e.cause});
            check("redirect_count", {28'd0, bus.exc_count}, {28'd0, e.cnt});
         end
      end
   end

   initial begin
      clr();
      rst = 1'b1;
      cyc();
      cyc();
      check("rst_flush", {31'd0, bus.flush}, 32'd0);
      check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'd0);
      check("rst_epc", bus.epc, 32'd0);
      check("rst_cause", {27'd0, bus.cause}, 32'd0);
      check("rst_in_handler", {31'd0, bus.in_handler}, 32'd0);
      check("rst_count", {28'd0, bus.exc_count}, 32'd0);
      check("rst_fatal", {31'd0, bus.fatal}, 32'd0);
      rst = 1'b0;
      cyc();

      // Overflow on add.
      raise(32'h40, 2'b01, 6'b100000, 6'd0, 1'b0);
      bump();
      push(32'h0000_4180, 32'h40, 5'd12);
      cyc();
      clr();
      cyc();
      check("ov_in_handler", {31'd0, bus.in_handler}, 32'd1);
      check("ov_epc", bus.epc, 32'h40);
      check("ov_cause", {27'd0, bus.cause}, 32'd12);
      check("ov_count", {28'd0, bus.exc_count}, 32'd1);
      check("handler_flush", {31'd0, bus.flush}, 32'd0);

      // Nested error in the handler is masked.
      raise(32'h200, 2'b01, 6'b101010, 6'd0, 1'b0);
      cyc();
      clr();
      cyc();
      check("mask_epc", bus.epc, 32'h40);
      check("mask_count", {28'd0, bus.exc_count}, 32'd1);
      check("mask_in_handler", {31'd0, bus.in_handler}, 32'd1);

      // eret together with an error: eret wins.
      raise(32'h300, 2'b01, 6'b100000, 6'd0, 1'b1);
      push(32'h40, 32'h40, 5'd12);
      cyc();
      clr();
      cyc();
      check("ret_in_handler", {31'd0, bus.in_handler}, 32'd0);
      cyc();
      check("ret_drop_count", {28'd0, bus.exc_count}, 32'd1);

      // Reserved instruction (slt with error).
      raise(32'h100, 2'b01, 6'b101010, 6'd0, 1'b0);
      bump();
      push(32'h0000_4180, 32'h100, 5'd10);
      cyc();
      clr();
      cyc();
      check("ri_cause", {27'd0, bus.cause}, 32'd10);
      check("ri_epc", bus.epc, 32'h100);
      cyc();
      cyc();
      bus.eret = 1'b1;
      push(32'h100, 32'h100, 5'd10);
      cyc();
      bus.eret = 1'b0;
      check("ri_return_in_handler", {31'd0, bus.in_handler}, 32'd0);
      cyc();
      check("ri_idle_flush", {31'd0, bus.flush}, 32'd0);

      // I-type addi overflow.
      raise(32'h500, 2'b00, 6'd0, 6'b001000, 1'b0);
      bump();
      push(32'h0000_4180, 32'h500, 5'd12);
      cyc();
      clr();
      cyc();
      check("addi_cause", {27'd0, bus.cause}, 32'd12);
      do_ret(32'h500, 5'd12);

      // Stalled error is deferred until stall drops.
      raise(32'h600, 2'b00, 6'd0, 6'b001101, 1'b0);
      bus.stall = 1'b1;
      repeat (3) cyc();
      check("stall_no_flush", {31'd0, bus.flush}, 32'd0);
      check("stall_no_handler", {31'd0, bus.in_handler}, 32'd0);
      bus.stall = 1'b0;
      bump();
      push(32'h0000_4180, 32'h600, 5'd10);
      cyc();
      clr();
      cyc();
      check("stall_epc", bus.epc, 32'h600);
      do_ret(32'h600, 5'd10);

      // eret alone in IDLE changes nothing.
      bus.eret = 1'b1;
      cyc();
      bus.eret = 1'b0;
      cyc();
      check("idle_eret_redirect_pc", bus.redirect_pc, 32'h600);
      check("idle_eret_in_handler", {31'd0, bus.in_handler}, 32'd0);
      check("idle_eret_count", {28'd0, bus.exc_count}, exp_cnt);

      // Error with eret in IDLE: capture wins (sub overflow).
      raise(32'h700, 2'b01, 6'b100010, 6'd0, 1'b1);
      bump();
      push(32'h0000_4180, 32'h700, 5'd12);
      cyc();
      clr();
      cyc();
      check("cap_wins_in_handler", {31'd0, bus.in_handler}, 32'd1);

      // Asynchronous reset mid-handler.
      #3 rst = 1'b1;
      #1;
      check("arst_in_handler", {31'd0, bus.in_handler}, 32'd0);
      check("arst_epc", bus.epc, 32'd0);
      check("arst_count", {28'd0, bus.exc_count}, 32'd0);
      check("arst_redirect_pc", bus.redirect_pc, 32'd0);
      cyc();
      rst = 1'b0;
      exp_cnt = 0;
      cyc();
      bus.eret = 1'b1;
      cyc();
      bus.eret = 1'b0;
      cyc();
      check("post_rst_eret_in_handler", {31'd0, bus.in_handler}, 32'd0);

      // Saturation: 2^CNT_W + 1 exceptions.
      for (int i = 0; i < (1 << c_CW) + 1; i++) begin
         logic [31:0] pc;
         pc = 32'h1000 + 32'(i * 4);
         raise(pc, 2'b00, 6'd0, 6'b001000, 1'b0);
         bump();
         push(32'h0000_4180, pc, 5'd12);
         cyc();
         clr();
         cyc();
         do_ret(pc, 5'd12);
      end
      check("sat_count", {28'd0, bus.exc_count}, 32'hF);

`ifdef EXC_TIMEOUT_EN
      // Watchdog expiry.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_cnt = 0;
      cyc();
      raise(32'h800, 2'b01, 6'b100000, 6'd0, 1'b0);
      bump();
      push(32'h0000_4180, 32'h800, 5'd12);
      cyc();
      clr();
      cyc();
      repeat (7) cyc();
      check("wd_cycle8_fatal", {31'd0, bus.fatal}, 32'd0);
      cyc();
      check("wd_fatal", {31'd0, bus.fatal}, 32'd1);
      check("wd_halt_flush", {31'd0, bus.flush}, 32'd1);
      check("wd_halt_redirect", {31'd0, bus.redirect}, 32'd0);
      bus.eret = 1'b1;
      cyc();
      raise(32'h880, 2'b01, 6'b100000, 6'd0, 1'b0);
      cyc();
      clr();
      cyc();
      check("wd_sticky_fatal", {31'd0, bus.fatal}, 32'd1);
      check("wd_sticky_flush", {31'd0, bus.flush}, 32'd1);

      // eret on the limit cycle wins.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_cnt = 0;
      cyc();
      raise(32'h900, 2'b01, 6'b100000, 6'd0, 1'b0);
      bump();
      push(32'h0000_4180, 32'h900, 5'd12);
      cyc();
      clr();
      cyc();
      repeat (7) cyc();
      bus.eret = 1'b1;
      push(32'h900, 32'h900, 5'd12);
      cyc();
      bus.eret = 1'b0;
      check("wd_eret_fatal", {31'd0, bus.fatal}, 32'd0);
      cyc();
      check("wd_eret_idle_flush", {31'd0, bus.flush}, 32'd0);
      check("wd_eret_idle_fatal", {31'd0, bus.fatal}, 32'd0);
`endif

      repeat (3) cyc();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_exception_ctrl.md
Name: alu_exception_ctrl

Overview:
- Consumes the ALU error flag in the EX stage of the single-issue MIPS core.
- Classifies the error as arithmetic overflow or reserved instruction, and captures the faulting PC.
- Flushes the pipeline and redirects fetch to the exception handler.
- On eret, returns fetch to the captured PC.

Parameters:
HANDLER_ADDR, 32'h0000_4180, fetch address of the exception handler
CNT_W, 16, width of the exception counter
TIMEOUT_CYCLES, 1024, handler watchdog limit; used only with EXC_TIMEOUT_EN

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_valid  input  1  EX stage holds a valid ALU-using instruction (alu_use)
alu_type  input  2  ALU type of EX instruction: 01 R-type, 00 I-type
opcode  input  6  opcode of EX instruction
fun  input  6  funct field of EX instruction
alu_err  input  1  ALU error flag for the EX instruction
ex_pc  input  32  PC of the EX instruction
eret  input  1  eret instruction in EX this cycle (single-cycle pulse)
stall  input  1  pipeline stalled; EX contents not advancing
flush  output  1  kill IF/ID/EX contents this cycle
redirect  output  1  fetch must load redirect_pc this cycle
redirect_pc  output  32  target fetch address
epc  output  32  captured faulting PC
cause  output  5  captured cause: 5'd12 overflow, 5'd10 reserved instruction
in_handler  output  1  handler executing; nested exceptions masked
exc_count  output  CNT_W  number of exceptions taken, saturating
fatal  output  1  handler watchdog expired (optional feature)

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - flush, redirect, in_handler, fatal = 0.
  - redirect_pc, epc, cause, exc_count, watchdog count = 0.
  - Reset mid-handler abandons the handler; epc is lost.
- All outputs are registered.
- Capture condition: state IDLE & ex_valid & alu_err & !stall, sampled at clock edge N.
- Cause classification at capture:
  - alu_type==01 with fun 100000 or 100010 -> 12.
  - alu_type==00 with opcode 001000 -> 12.
  - Any other combination -> 10.
- FSM states:
  - IDLE:
    - On capture: epc <= ex_pc, cause <= class, exc_count += 1 (holds at all-ones), go to FLUSH.
    - eret in IDLE is ignored.
    - alu_err with eret in the same cycle: capture wins.
  - FLUSH, exactly one cycle:
    - flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
    - Go to HANDLER.
    - Latency: error at edge N -> flush/redirect visible in cycle N+1.
  - HANDLER:
    - in_handler=1.
    - alu_err is ignored and not counted; epc and cause are frozen.
    - On eret: go to RETURN.
    - eret together with alu_err: eret wins, error dropped.
  - RETURN, exactly one cycle:
    - flush=1, redirect=1, redirect_pc=epc, in_handler=0.
    - Go to IDLE.
    - The faulting instruction is re-fetched; software fixes the cause before eret.
- flush and redirect are 0 in IDLE and HANDLER.
- redirect_pc holds its last value when redirect=0.
- stall high in FLUSH or RETURN does not extend the pulse; fetch must honour redirect regardless of stall.
- An error while stall=1 is not captured; it is re-evaluated once stall drops.

Optional Feature:
- Macro: EXC_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to HANDLER and increments each HANDLER cycle.
  - On reaching TIMEOUT_CYCLES without eret: fatal=1 (sticky until rst) and FSM enters HALT.
  - HALT holds flush=1 and redirect=0, and ignores all inputs.
  - eret on the same cycle the count reaches the limit wins; no fatal.
- Undefined: no counter, no HALT state, fatal tied to 0.

Test Plan:
- Overflow add: after reset, alu_type=01, fun=100000, ex_pc=0x0000_0040, alu_err=1 for one cycle -> next cycle flush=1, redirect=1, redirect_pc=0x0000_4180; afterwards epc=0x40, cause=12, in_handler=1, exc_count=1.
- Illegal funct: alu_type=01, fun=101010, alu_err=1, ex_pc=0x100 -> cause=10, epc=0x100. Then eret -> one-cycle redirect to 0x100, flush=1, then IDLE with in_handler=0.
- Masking: in HANDLER, pulse alu_err with ex_pc=0x200 -> epc stays 0x40, exc_count stays 1. eret with alu_err in the same cycle -> RETURN to 0x40.
- Stall and priority:
  - alu_err=1 with stall=1 for 3 cycles -> no flush; stall drops -> flush next cycle.
  - In IDLE, eret alone -> no outputs change.
- Reset mid-handler: assert rst asynchronously during HANDLER (between edges) -> all outputs 0 immediately; a following eret does nothing. Saturation: force 2^CNT_W+1 exceptions -> exc_count=0xFFFF.
- EXC_TIMEOUT_EN with TIMEOUT_CYCLES=8:
  - No eret after entry -> fatal=1 on the 8th HANDLER cycle, flush held at 1; a later eret is ignored.
  - eret on cycle 8 -> fatal=0, normal RETURN.
